// File: rtl/bram_pkg.sv
// Purpose: shared constants and lane-merge helper for the block-RAM family.
// Latency: n/a (package, combinational helper only).
// Backpressure: n/a.
package bram_pkg;

    // Read-during-write collision modes.
    localparam int RDW_OLD = 0;
    localparam int RDW_NEW = 1;

    // Widest word the merge helper handles. Callers zero-extend their operands
    // and cast the result back down to their own width.
    localparam int MERGE_MAXW = 1024;
    localparam int MERGE_IW   = $clog2(MERGE_MAXW);

    // Each result bit comes from new_w when its byte lane is set in lane_msk,
    // otherwise from old_w. The mask holds one bit per lane of width bytew.
    function automatic logic [MERGE_MAXW-1:0] lane_merge(
        input logic [MERGE_MAXW-1:0] old_w,
        input logic [MERGE_MAXW-1:0] new_w,
        input logic [MERGE_MAXW-1:0] lane_msk,
        input int                    bytew
    );
        logic [MERGE_MAXW-1:0] res;
        res = old_w;
        for (int b = 0; b < MERGE_MAXW; b++) begin
            if (lane_msk[MERGE_IW'(b / bytew)]) begin
                res[MERGE_IW'(b)] = new_w[MERGE_IW'(b)];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/bram_rd_pipe.sv
// Purpose: 1- or 2-stage valid pipeline with a registered data copy on stage 2.
// Latency: STAGES cycles from i_vld to o_vld (stage-1 data is registered upstream).
// Backpressure: none; the stage-2 data register loads only on a valid beat.
//
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_vld          : read accepted this edge (stage-1 valid input)
//   i_dat          : stage-1 data word, already registered by the caller
//   o_dat, o_vld   : pipeline output word and its one-cycle valid strobe
module bram_rd_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_vld,
    input  logic [WIDTH-1:0] i_dat,
    output logic [WIDTH-1:0] o_dat,
    output logic             o_vld
);

    logic r_s1_vld;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1_vld <= 1'b0;
        end else begin
            r_s1_vld <= i_vld;
        end
    end

    generate
        if (STAGES == 1) begin : g_one
            assign o_dat = i_dat;
            assign o_vld = r_s1_vld;
        end else begin : g_two
            logic [WIDTH-1:0] r_s2_dat;
            logic             r_s2_vld;

            // Data only moves on a valid beat so the output holds between reads.
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_s2_dat <= '0;
                    r_s2_vld <= 1'b0;
                end else begin
                    r_s2_vld <= r_s1_vld;
                    if (r_s1_vld) begin
                        r_s2_dat <= i_dat;
                    end
                end
            end

            assign o_dat = r_s2_dat;
            assign o_vld = r_s2_vld;
        end

        if (STAGES != 1 && STAGES != 2) begin : g_err_stages
            $error("bram_rd_pipe: STAGES must be 1 or 2");
        end
    endgenerate

endmodule

// File: rtl/bram_sdp_be.sv
// Purpose: single-clock simple dual-port RAM, byte-lane writes on A, enabled reads on B.
// Latency: READ_LAT (1 or 2) cycles from re to data_valid; one result per cycle.
// Backpressure: none; data_out holds its last value while re is low.
//
// Ports:
//   clk, rst_n             : clock, asynchronous active-low reset
//   we, addr_write, data_in: port A per-lane write enable, address, data
//   re, addr_read          : port B read enable and address
//   data_out, data_valid   : port B read word and its one-cycle valid strobe
module bram_sdp_be
    import bram_pkg::*;
#(
    parameter  int WIDTH    = 32,
    parameter  int DEPTH    = 1024,
    parameter  int BYTEW    = 8,
    parameter  int READ_LAT = 1,
    parameter  int RDW_MODE = 0,
    localparam int ADDRW    = $clog2(DEPTH),
    localparam int NBYTE    = WIDTH / BYTEW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NBYTE-1:0] we,
    input  logic [ADDRW-1:0] addr_write,
    input  logic [WIDTH-1:0] data_in,
    input  logic             re,
    input  logic [ADDRW-1:0] addr_read,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid
);

    // One extra bit so DEPTH itself is representable when it is a power of two.
    localparam logic [ADDRW:0] DEPTH_L = (ADDRW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];

    logic             w_wr_in;
    logic             w_rd_in;
    logic             w_hit;
    logic [WIDTH-1:0] w_s1_dat;

    // Stage 1: raw RAM word plus the collision mask and forwarded write data.
    logic [WIDTH-1:0] r_ram;
    logic [WIDTH-1:0] r_fwd_dat;
    logic [NBYTE-1:0] r_fwd_msk;
    logic             r_live;

    assign w_wr_in = ({1'b0, addr_write} < DEPTH_L);
    assign w_rd_in = ({1'b0, addr_read}  < DEPTH_L);

    // Out-of-range reads return zero, so they never count as a collision.
    assign w_hit = (RDW_MODE == RDW_NEW) && w_rd_in && (we != '0)
                && (addr_write == addr_read);

    always_ff @(posedge clk) begin
        if (rst_n && w_wr_in) begin
            for (int i = 0; i < NBYTE; i++) begin
                if (we[i]) begin
                    r_mem[addr_write][i*BYTEW +: BYTEW] <= data_in[i*BYTEW +: BYTEW];
                end
            end
        end
    end

    // Kept free of reset so it maps onto the BRAM's own read latch; r_live
    // masks it to zero until the first read after reset.
    always_ff @(posedge clk) begin
        if (rst_n && re) begin
            r_ram <= w_rd_in ? r_mem[addr_read] : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_live    <= 1'b0;
            r_fwd_msk <= '0;
            r_fwd_dat <= '0;
        end else if (re) begin
            r_live    <= 1'b1;
            r_fwd_msk <= w_hit ? we : '0;
            r_fwd_dat <= data_in;
        end
    end

    // Merge sits in fabric ahead of the final register (or the port at latency 1).
    assign w_s1_dat = r_live
        ? WIDTH'(lane_merge(MERGE_MAXW'(r_ram), MERGE_MAXW'(r_fwd_dat),
                            MERGE_MAXW'(r_fwd_msk), BYTEW))
        : '0;

    bram_rd_pipe #(
        .WIDTH  (WIDTH),
        .STAGES (READ_LAT)
    ) u_rd_pipe (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_vld   (re),
        .i_dat   (w_s1_dat),
        .o_dat   (data_out),
        .o_vld   (data_valid)
    );

    generate
        if (WIDTH % BYTEW != 0) begin : g_err_width
            $error("bram_sdp_be: WIDTH must be a multiple of BYTEW");
        end
        if (WIDTH > MERGE_MAXW) begin : g_err_maxw
            $error("bram_sdp_be: WIDTH exceeds lane_merge capacity");
        end
        if (READ_LAT != 1 && READ_LAT != 2) begin : g_err_lat
            $error("bram_sdp_be: READ_LAT must be 1 or 2");
        end
        if (RDW_MODE != RDW_OLD && RDW_MODE != RDW_NEW) begin : g_err_rdw
            $error("bram_sdp_be: RDW_MODE must be 0 or 1");
        end
    endgenerate

endmodule
